// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared writeback-path definitions: GPR write-data select codes, grant
// source encodings and arbiter state/record types.
package gpr_wb_arbiter_pkg;

    localparam int GPR_AW = 5;
    localparam int GPR_SW = 3;

    // Select codes for the GPR write-data multiplexer
    localparam logic [GPR_SW-1:0] GPR_W_SEL_ALU = 3'd0;
    localparam logic [GPR_SW-1:0] GPR_W_SEL_MEM = 3'd1;
    localparam logic [GPR_SW-1:0] GPR_W_SEL_MUL = 3'd2;
    localparam logic [GPR_SW-1:0] GPR_W_SEL_PC  = 3'd3;
    localparam logic [GPR_SW-1:0] GPR_W_SEL_CSR = 3'd4;

    // Source of the write currently on the GPR port
    localparam logic [1:0] GSRC_NONE = 2'd0;
    localparam logic [1:0] GSRC_PIPE = 2'd1;
    localparam logic [1:0] GSRC_MUL  = 2'd2;
    localparam logic [1:0] GSRC_MEM  = 2'd3;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_e;

    // One GPR port write as launched into the output register
    typedef struct packed {
        logic              wen;
        logic [GPR_AW-1:0] waddr;
        logic [GPR_SW-1:0] sel;
        logic [1:0]        src;
    } gpr_wr_t;

    localparam gpr_wr_t GPR_WR_IDLE = '{wen: 1'b0, waddr: '0, sel: GPR_W_SEL_ALU, src: GSRC_NONE};

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on a tie
// the pointer decides. The pointer moves past the winner when upd is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // ptr = 0 prefers req[0], ptr = 1 prefers req[1]
    logic ptr;

    // Tie broken by the pointer, otherwise pass the single request through
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end

    // Hand priority to the other requester once a grant actually completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (upd && (gnt != 2'b00))
            ptr <= gnt[0];
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port scheduler: the pipeline writeback has priority, the
// multiplier and load completions share leftover slots round-robin, and a
// starvation counter forces a one-cycle pipeline stall so async results drain.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pipe_wen,
    input  logic [GPR_AW-1:0] i_pipe_waddr,
    input  logic [GPR_SW-1:0] i_pipe_wdata_sel,
    output logic              o_pipe_stall,
    input  logic              i_mul_valid,
    input  logic [GPR_AW-1:0] i_mul_waddr,
    output logic              o_mul_ready,
    input  logic              i_mem_valid,
    input  logic [GPR_AW-1:0] i_mem_waddr,
    output logic              o_mem_ready,
    output logic              o_gpr_wen,
    output logic [GPR_AW-1:0] o_gpr_waddr,
    output logic [GPR_SW-1:0] o_gpr_wdata_sel,
    output logic [1:0]        o_grant_src
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_inc;
    logic       in_force;
    logic       async_ok;
    logic       pipe_gnt;
    logic       mul_gnt;
    logic       mem_gnt;
    logic       starve_inc;
    logic       starve_hit;
    logic [1:0] rr_gnt;
    gpr_wr_t    wr_nxt;

    assign in_force = (state == ST_FORCE);
    // Async sources may write when the pipe is idle or is being held off
    assign async_ok = in_force | ~i_pipe_wen;
    assign pipe_gnt = ~in_force & i_pipe_wen;

    rr_arb2 u_rr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .req   ({i_mem_valid, i_mul_valid}),
        .upd   (async_ok),
        .gnt   (rr_gnt)
    );

    assign mul_gnt = async_ok & rr_gnt[0];
    assign mem_gnt = async_ok & rr_gnt[1];

    // Readies are masked during reset so no handshake completes while the
    // grant register is being cleared
    assign o_mul_ready  = mul_gnt & i_rst_n;
    assign o_mem_ready  = mem_gnt & i_rst_n;
    assign o_pipe_stall = in_force;

    // An async request losing to the pipe counts toward a forced stall
    assign starve_inc     = ~in_force & (i_mul_valid | i_mem_valid) & i_pipe_wen;
    assign starve_cnt_inc = starve_cnt + 4'd1;
    assign starve_hit     = starve_inc & (starve_cnt_inc >= LIMIT);

    // Build the write record for the winner; r0 writes complete but never enable
    always_comb begin
        wr_nxt = GPR_WR_IDLE;
        if (pipe_gnt) begin
            wr_nxt.waddr = i_pipe_waddr;
            wr_nxt.sel   = i_pipe_wdata_sel;
            wr_nxt.src   = GSRC_PIPE;
        end else if (mul_gnt) begin
            wr_nxt.waddr = i_mul_waddr;
            wr_nxt.sel   = GPR_W_SEL_MUL;
            wr_nxt.src   = GSRC_MUL;
        end else if (mem_gnt) begin
            wr_nxt.waddr = i_mem_waddr;
            wr_nxt.sel   = GPR_W_SEL_MEM;
            wr_nxt.src   = GSRC_MEM;
        end
        wr_nxt.wen = (wr_nxt.src != GSRC_NONE) && (wr_nxt.waddr != '0);
    end

    // State, starvation counter and registered GPR port outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_NORMAL;
            starve_cnt      <= '0;
            o_gpr_wen       <= 1'b0;
            o_gpr_waddr     <= '0;
            o_gpr_wdata_sel <= GPR_W_SEL_ALU;
            o_grant_src     <= GSRC_NONE;
        end else begin
            o_gpr_wen       <= wr_nxt.wen;
            o_gpr_waddr     <= wr_nxt.waddr;
            o_gpr_wdata_sel <= wr_nxt.sel;
            o_grant_src     <= wr_nxt.src;
            case (state)
                ST_NORMAL: begin
                    if (starve_hit) begin
                        state      <= ST_FORCE;
                        starve_cnt <= '0;
                    end else if (starve_inc) begin
                        starve_cnt <= (starve_cnt_inc > LIMIT) ? LIMIT : starve_cnt_inc;
                    end else begin
                        // async grant taken or nothing async pending
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state      <= ST_NORMAL;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Schedules the single GPR write port between three producers:
  - the in-order pipeline writeback;
  - the multi-cycle multiplier completion;
  - the out-of-band memory load completion.
- Each cycle it picks at most one writer and drives the registered GPR write enable, address and wdata select code. The wdata select code steers the existing GPR write-data multiplexer.
- Pipeline has priority. A starvation counter forces a one-cycle pipeline stall so that async completions always make progress.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a pending async request may lose to the pipeline before a forced stall. Legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pipe_wen  in  1  pipeline writeback request
- i_pipe_waddr  in  5  pipeline destination register
- i_pipe_wdata_sel  in  3  pipeline GPR_W_SEL_* code
- o_pipe_stall  out  1  pipeline must hold its writeback request this cycle
- i_mul_valid  in  1  multiplier result pending
- i_mul_waddr  in  5  multiplier destination
- o_mul_ready  out  1  multiplier result accepted this cycle
- i_mem_valid  in  1  load result pending
- i_mem_waddr  in  5  load destination
- o_mem_ready  out  1  load result accepted this cycle
- o_gpr_wen  out  1  GPR write enable (registered)
- o_gpr_waddr  out  5  GPR write address (registered)
- o_gpr_wdata_sel  out  3  select code to the wdata mux (registered)
- o_grant_src  out  2  registered source of current write: 0 none, 1 pipe, 2 mul, 3 mem

Behaviour:
Clock and reset:
- One clock, i_clk.
- Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - o_gpr_wen = 0, o_gpr_waddr = 0, o_gpr_wdata_sel = GPR_W_SEL_ALU, o_grant_src = 0.
  - State NORMAL, starvation counter 0, round-robin pointer = mul.
- Reset mid-transfer drops any grant in flight. Requesters re-present, since valid is held until ready.

Handshake and latency:
- Async handshake is valid/ready. Requesters hold valid and waddr stable until ready.
- o_mul_ready and o_mem_ready are combinational and asserted only in the grant cycle.
- Latency: grant decided in cycle N; o_gpr_* reflect it in cycle N+1 for exactly one cycle. With no grant, o_gpr_wen = 0 in N+1.
- Wdata select for each winner:
  - pipe: i_pipe_wdata_sel passed through;
  - mul: GPR_W_SEL_MUL;
  - mem: GPR_W_SEL_MEM.
- waddr == 0 (r0): the handshake or grant completes normally but o_gpr_wen stays 0. o_grant_src still records the source.

States:
- NORMAL:
  - If i_pipe_wen, grant pipe and o_pipe_stall = 0.
  - Else grant the round-robin winner among the valid async requesters.
  - If exactly one async requester is valid, it wins regardless of the pointer.
- FORCE:
  - o_pipe_stall = 1 (combinational from state).
  - Pipe not granted; async round-robin winner granted.
  - Always returns to NORMAL next cycle.
  - Lasts one cycle.

Starvation counter:
- Increments in NORMAL when (i_mul_valid | i_mem_valid) & i_pipe_wen.
- Clears on any async grant, or when no async valid is present.
- Saturates at STARVE_LIMIT.
- Reaching STARVE_LIMIT moves NORMAL to FORCE on the next edge, and the counter clears.

Round-robin pointer:
- After an async grant, the pointer moves to the other async source.
- Unchanged on pipe grants.

Simultaneous events:
- Pipe, mul and mem all valid in NORMAL below the limit: pipe wins.
- Entering FORCE with no async valid (requester withdrew, illegal): no grant; o_pipe_stall still 1 for that cycle.

Decomposition:
- GPR_W_SEL_* codes and grant_src encodings live in the shared defines header used by the writeback path.
- Sub-module rr_arb2: 2-requester round-robin with registered pointer and update-on-grant input.

Test Plan:
- Reset checks:
  - i_rst_n low mid-grant → all outputs 0 and o_gpr_wdata_sel = GPR_W_SEL_ALU immediately.
  - After release, the first mul-only request is granted the next cycle.
- Single pipe write: i_pipe_wen = 1, waddr = 5, sel = PC → next cycle o_gpr_wen = 1, waddr = 5, sel = GPR_W_SEL_PC, grant_src = 1.
- Mul and mem valid together, pipe idle, 4 cycles → grants alternate mul, mem, mul, mem.
  - o_gpr_wdata_sel alternates MUL/MEM.
  - ready pulses one cycle each.
- Pipe continuously writing, mul valid, STARVE_LIMIT = 4:
  - o_pipe_stall = 1 on the 5th cycle and o_mul_ready = 1 that cycle.
  - The pipe write resumes the cycle after.
- r0 write: mem valid with waddr = 0 → o_mem_ready = 1, next cycle o_gpr_wen = 0, grant_src = 3.
- Mul valid with pipe idle → o_mul_ready = 1 combinationally the same cycle; counter stays 0.
